// File: rtl/param_seq_mac.sv
// Three-stage sequential MAC with element-wise add/multiply modes and a saturating downcast.
// Define SEQ_MAC_ROUND_EN to round half-up before the FRAC_BITS shift; otherwise the shift truncates.
module param_seq_mac #(
  parameter int DWIDTH    = 16,
  parameter int ACC_WIDTH = 40,
  parameter int FRAC_BITS = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    a,
  input  logic [DWIDTH-1:0]    b,
  input  logic [1:0]           mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DWIDTH-1:0]    out,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] out_count
);

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;
  typedef enum logic [1:0] {OP_MAC = 2'b00, OP_ADD = 2'b01, OP_MUL = 2'b10} op_t;

  localparam int PW = 2 * DWIDTH;
  localparam int XW = ACC_WIDTH + 1;
  localparam logic signed [XW-1:0] OUT_MAX = {{(XW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] OUT_MIN = {{(XW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  state_t r_state, w_state_next;
  op_t    w_op;
  logic   w_en, w_accept;

  // One enable freezes the whole pipeline while a result waits for the consumer.
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = reset || w_en;
  assign w_accept = in_valid && w_en;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_op         = OP_MAC;
    if (r_state == ST_IDLE) begin
      case (mode)
        2'b01:   w_op = OP_ADD;
        2'b10:   w_op = OP_MUL;
        default: w_op = OP_MAC;
      endcase
    end
    if (w_accept && w_op == OP_MAC) begin
      if (r_state == ST_IDLE && !in_last)      w_state_next = ST_ACCUM;
      else if (r_state == ST_ACCUM && in_last) w_state_next = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Stage 1: operand capture; mode is forced to MAC for all elements after the first of a sequence.
  logic                     r_s1_valid, r_s1_first, r_s1_last;
  op_t                      r_s1_op;
  logic signed [DWIDTH-1:0] r_s1_a, r_s1_b;

  always_ff @(posedge clk) begin
    if (reset)     r_s1_valid <= 1'b0;
    else if (w_en) r_s1_valid <= in_valid;
  end

  // NOTE: datapath registers carry no reset; their contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= w_op;
      r_s1_first <= (r_state == ST_IDLE);
      r_s1_last  <= in_last;
    end
  end

  // Stage 2: full-precision product or sign-extended sum.
  logic signed [PW-1:0] w_a_ext, w_b_ext, w_s2_res;
  logic signed [PW-1:0] r_s2_res;
  logic                 r_s2_valid, r_s2_first, r_s2_last;
  op_t                  r_s2_op;

  assign w_a_ext  = PW'(r_s1_a);
  assign w_b_ext  = PW'(r_s1_b);
  assign w_s2_res = (r_s1_op == OP_ADD) ? (w_a_ext + w_b_ext) : (w_a_ext * w_b_ext);

  always_ff @(posedge clk) begin
    if (reset)     r_s2_valid <= 1'b0;
    else if (w_en) r_s2_valid <= r_s1_valid;
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s2_res   <= w_s2_res;
      r_s2_op    <= r_s1_op;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
    end
  end

  // Stage 3: accumulate (wrapping), then shift and clamp into the output register.
  logic signed [ACC_WIDTH-1:0] r_acc, w_prod_ext, w_acc_next, w_val;
  logic [CNT_WIDTH-1:0]        r_cnt, w_cnt_next;
  logic                        w_is_mac, w_emit;

  assign w_is_mac   = (r_s2_op == OP_MAC);
  assign w_prod_ext = ACC_WIDTH'(r_s2_res);
  assign w_acc_next = r_s2_first ? w_prod_ext : (r_acc + w_prod_ext);
  assign w_cnt_next = r_s2_first ? CNT_WIDTH'(1)
                    : ((&r_cnt) ? r_cnt : (r_cnt + CNT_WIDTH'(1)));
  assign w_val      = w_is_mac ? w_acc_next : w_prod_ext;
  assign w_emit     = r_s2_valid && (!w_is_mac || r_s2_last);

  logic signed [XW-1:0] w_pre, w_shr;

`ifdef SEQ_MAC_ROUND_EN
  if (FRAC_BITS > 0) begin : g_round
    localparam logic signed [XW-1:0] RND = XW'(1) << (FRAC_BITS - 1);
    assign w_pre = XW'(w_val) + RND;
  end else begin : g_trunc
    assign w_pre = XW'(w_val);
  end
`else
  assign w_pre = XW'(w_val);
`endif

  assign w_shr = w_pre >>> FRAC_BITS;

  logic [DWIDTH-1:0] w_out_next;
  logic              w_sat_next;

  always_comb begin
    w_out_next = w_shr[DWIDTH-1:0];
    w_sat_next = 1'b0;
    if (w_shr > OUT_MAX) begin
      w_out_next = OUT_MAX[DWIDTH-1:0];
      w_sat_next = 1'b1;
    end else if (w_shr < OUT_MIN) begin
      w_out_next = OUT_MIN[DWIDTH-1:0];
      w_sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (w_en) begin
      out_valid <= w_emit;
      if (w_emit) begin
        out       <= w_out_next;
        out_sat   <= w_sat_next;
        out_count <= w_is_mac ? w_cnt_next : CNT_WIDTH'(1);
      end
      if (r_s2_valid && w_is_mac) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_param_seq_mac.sv
// Self-checking bench for param_seq_mac: directed scenarios plus randomized traffic against a
// transaction-level model; a FRAC_BITS=0 and a FRAC_BITS=8 instance run in lockstep.
module tb_param_seq_mac;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_last, out_ready;
  logic [DW-1:0] a, b;
  logic [1:0]    mode;
  logic          in_ready, out_valid, out_sat;
  logic [DW-1:0] out;
  logic [CW-1:0] out_count;
  logic          in_ready8, out_valid8, out_sat8;
  logic [DW-1:0] out8;
  logic [CW-1:0] out_count8;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] out0;
    logic          sat0;
    logic [DW-1:0] out8;
    logic          sat8;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t   exp_q[$];
  bit     m_in_seq;
  longint m_acc;
  int     m_cnt;

  logic          obs_ready, obs_ready8, obs_ov, obs_ov8, obs_acc, obs_ordy, obs_sat, obs_sat8;
  logic [DW-1:0] obs_out, obs_out8;
  logic [CW-1:0] obs_cnt, obs_cnt8;

  param_seq_mac #(.DWIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_sat(out_sat), .out_count(out_count)
  );

  param_seq_mac #(.DWIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(8), .CNT_WIDTH(CW)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .a(a), .b(b),
    .mode(mode), .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
    .out(out8), .out_sat(out_sat8), .out_count(out_count8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Shift (with optional half-up rounding) then clamp to the signed 16-bit range; returns {sat, value}.
  function automatic logic [DW:0] downcast(input longint v, input int frac);
    longint t;
    t = v;
`ifdef SEQ_MAC_ROUND_EN
    if (frac > 0) t = t + (longint'(1) << (frac - 1));
`endif
    t = t >>> frac;
    if (t > 32767)  return {1'b1, 16'h7FFF};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[DW-1:0]};
  endfunction

  function automatic void model_push(input longint v, input int cnt);
    exp_t        e;
    logic [DW:0] r0, r8;
    r0     = downcast(v, 0);
    r8     = downcast(v, 8);
    e.out0 = r0[DW-1:0];
    e.sat0 = r0[DW];
    e.out8 = r8[DW-1:0];
    e.sat8 = r8[DW];
    e.cnt  = CW'(cnt);
    exp_q.push_back(e);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_in_seq = 1'b0;
    m_acc    = 0;
    m_cnt    = 0;
  endfunction

  // Sequence semantics: a MAC sequence sums products until in_last; mode is ignored inside a sequence.
  function automatic void model_accept(input logic [DW-1:0] ia, ib, input logic [1:0] im, input logic il);
    longint sa, sb, p;
    int     op;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    op = m_in_seq ? 0 : ((im == 2'b01) ? 1 : (im == 2'b10) ? 2 : 0);
    p  = (op == 1) ? (sa + sb) : (sa * sb);
    if (op != 0) begin
      model_push(p, 1);
      return;
    end
    m_acc = m_in_seq ? (((m_acc + p) <<< (64 - AW)) >>> (64 - AW)) : p;
    m_cnt = m_in_seq ? ((m_cnt >= 255) ? 255 : m_cnt + 1) : 1;
    if (il) begin
      model_push(m_acc, m_cnt);
      m_in_seq = 1'b0;
    end else begin
      m_in_seq = 1'b1;
    end
  endfunction

  // Drive one cycle of inputs, snapshot outputs at the falling edge, feed the model on acceptance.
  task automatic cycle(input logic v, input logic [DW-1:0] ia, ib, input logic [1:0] im,
                       input logic il, input logic ordy);
    in_valid  = v;
    a         = ia;
    b         = ib;
    mode      = im;
    in_last   = il;
    out_ready = ordy;
    @(negedge clk);
    obs_ready  = in_ready;
    obs_ready8 = in_ready8;
    obs_ov     = out_valid;
    obs_ov8    = out_valid8;
    obs_out    = out;
    obs_out8   = out8;
    obs_sat    = out_sat;
    obs_sat8   = out_sat8;
    obs_cnt    = out_count;
    obs_cnt8   = out_count8;
    obs_ordy   = ordy;
    obs_acc    = v && in_ready;
    if (reset)        model_clear();
    else if (obs_acc) model_accept(ia, ib, im, il);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, ordy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", obs_ready);
    else n_pass++;
    idle(1'b1);
    reset = 1'b0;
    idle(1'b1);
    n_checks++;
    if ({obs_ov, obs_out, obs_sat, obs_cnt} !== {1'b0, 16'd0, 1'b0, 8'd0})
      $display("FAIL reset_outputs: got valid=%b out=%0d sat=%b cnt=%0d expected all 0",
               obs_ov, obs_out, obs_sat, obs_cnt);
    else n_pass++;
    n_checks++;
    if (obs_ready !== 1'b1) $display("FAIL reset_after_ready: got %b expected 1", obs_ready);
    else n_pass++;
  endtask

  task automatic test_mac();
    cycle(1'b1, 16'd2, 16'd3, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 16'd4, 16'd5, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 16'hFFFF, 16'd6, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_checks++;
      if (obs_ov !== (i == 2)) $display("FAIL mac_latency[%0d]: got valid=%b expected %b", i, obs_ov, (i == 2));
      else n_pass++;
    end
    n_checks++;
    if ({obs_out, obs_cnt, obs_sat} !== {16'd20, 8'd3, 1'b0})
      $display("FAIL mac_result: got out=%0d cnt=%0d sat=%b expected out=20 cnt=3 sat=0",
               $signed(obs_out), obs_cnt, obs_sat);
    else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_add_stream();
    cycle(1'b1, 16'd100, 16'hFFE2, 2'b01, 1'b0, 1'b1);
    cycle(1'b1, 16'd5, 16'd5, 2'b01, 1'b0, 1'b1);
    idle(1'b1);
    n_checks++;
    if (obs_ov !== 1'b0) $display("FAIL add_early: got valid=%b expected 0", obs_ov);
    else n_pass++;
    idle(1'b1);
    n_checks++;
    if ({obs_ov, obs_out, obs_cnt} !== {1'b1, 16'd70, 8'd1})
      $display("FAIL add_first: got valid=%b out=%0d cnt=%0d expected valid=1 out=70 cnt=1",
               obs_ov, $signed(obs_out), obs_cnt);
    else n_pass++;
    idle(1'b1);
    n_checks++;
    if ({obs_ov, obs_out, obs_cnt} !== {1'b1, 16'd10, 8'd1})
      $display("FAIL add_second: got valid=%b out=%0d cnt=%0d expected valid=1 out=10 cnt=1",
               obs_ov, $signed(obs_out), obs_cnt);
    else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_saturation();
    cycle(1'b1, 16'h7FFF, 16'h7FFF, 2'b10, 1'b0, 1'b1);
    cycle(1'b1, 16'h8000, 16'h7FFF, 2'b10, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    n_checks++;
    if ({obs_ov, obs_out, obs_sat} !== {1'b1, 16'h7FFF, 1'b1})
      $display("FAIL sat_pos: got valid=%b out=%h sat=%b expected valid=1 out=7fff sat=1",
               obs_ov, obs_out, obs_sat);
    else n_pass++;
    idle(1'b1);
    n_checks++;
    if ({obs_ov, obs_out, obs_sat} !== {1'b1, 16'h8000, 1'b1})
      $display("FAIL sat_neg: got valid=%b out=%h sat=%b expected valid=1 out=8000 sat=1",
               obs_ov, obs_out, obs_sat);
    else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ea [7] = '{16'd3, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60};
    logic [DW-1:0] eb [7] = '{16'd4, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    logic [1:0]    em [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    int   sent;
    int   got;
    int   stall_left;
    int   idx;
    logic ordy;
    exp_t e;
    sent       = 0;
    got        = 0;
    stall_left = 5;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 7; cyc++) begin
      ordy = (stall_left == 0);
      idx  = (sent < 7) ? sent : 6;
      cycle(sent < 7, ea[idx], eb[idx], em[idx], (idx == 0), ordy);
      if (obs_acc) sent++;
      if (obs_ov && !ordy) begin
        n_checks++;
        if (obs_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", obs_ready);
        else n_pass++;
        n_checks++;
        if ({obs_out, obs_sat, obs_cnt} !== {16'd12, 1'b0, 8'd1})
          $display("FAIL bp_hold: got out=%0d sat=%b cnt=%0d expected out=12 sat=0 cnt=1",
                   obs_out, obs_sat, obs_cnt);
        else n_pass++;
        stall_left--;
      end
      if (obs_ov && ordy) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL bp_result: unexpected output out=%0d", $signed(obs_out));
        end else begin
          e = exp_q.pop_front();
          if ({obs_out, obs_sat, obs_cnt, obs_out8, obs_sat8} !== {e.out0, e.sat0, e.cnt, e.out8, e.sat8})
            $display("FAIL bp_result: got out=%0d sat=%b cnt=%0d out8=%0d sat8=%b expected out=%0d sat=%b cnt=%0d out8=%0d sat8=%b",
                     $signed(obs_out), obs_sat, obs_cnt, $signed(obs_out8), obs_sat8,
                     $signed(e.out0), e.sat0, e.cnt, $signed(e.out8), e.sat8);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (got !== 7 || sent !== 7) $display("FAIL bp_count: got %0d results from %0d accepted expected 7 from 7", got, sent);
    else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_rounding();
    logic [DW-1:0] exp_r;
`ifdef SEQ_MAC_ROUND_EN
    exp_r = 16'd2;
`else
    exp_r = 16'd1;
`endif
    cycle(1'b1, 16'd24, 16'd16, 2'b00, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    n_checks++;
    if ({obs_ov8, obs_out8, obs_sat8} !== {1'b1, exp_r, 1'b0})
      $display("FAIL round_frac8: got valid=%b out=%0d sat=%b expected valid=1 out=%0d sat=0",
               obs_ov8, obs_out8, obs_sat8, exp_r);
    else n_pass++;
    n_checks++;
    if (obs_out !== 16'd384) $display("FAIL round_frac0: got out=%0d expected 384", obs_out);
    else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    int            n_out;
    logic [DW-1:0] last_out;
    logic [CW-1:0] last_cnt;
    n_out    = 0;
    last_out = '0;
    last_cnt = '0;
    cycle(1'b1, 16'd5, 16'd5, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 16'd6, 16'd6, 2'b00, 1'b0, 1'b1);
    reset = 1'b1;
    idle(1'b1);
    n_checks++;
    if (obs_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b expected 1", obs_ready);
    else n_pass++;
    reset = 1'b0;
    cycle(1'b1, 16'd7, 16'd1, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      if (obs_ov) begin
        n_out++;
        last_out = obs_out;
        last_cnt = obs_cnt;
      end
    end
    n_checks++;
    if (n_out !== 1 || last_out !== 16'd7 || last_cnt !== 8'd1)
      $display("FAIL rmid_result: got %0d outputs last out=%0d cnt=%0d expected 1 output out=7 cnt=1",
               n_out, last_out, last_cnt);
    else n_pass++;
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 260; i++) cycle(1'b1, 16'd1, 16'd1, 2'b00, (i == 259), 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    n_checks++;
    if ({obs_ov, obs_out, obs_cnt, obs_sat} !== {1'b1, 16'd260, 8'd255, 1'b0})
      $display("FAIL count_sat: got valid=%b out=%0d cnt=%0d sat=%b expected valid=1 out=260 cnt=255 sat=0",
               obs_ov, obs_out, obs_cnt, obs_sat);
    else n_pass++;
    idle(1'b1);
  endtask

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic          v, il, ordy, hold;
    logic [DW-1:0] ra, rb, held_out;
    logic [1:0]    rm;
    logic [CW-1:0] held_cnt;
    exp_t          e;
    hold     = 1'b0;
    held_out = '0;
    held_cnt = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 620; cyc++) begin
      v    = (cyc < 600) && ($urandom_range(0, 3) != 0);
      ra   = rand_operand();
      rb   = rand_operand();
      rm   = 2'($urandom_range(0, 3));
      il   = ($urandom_range(0, 3) == 0);
      ordy = (cyc >= 600) || ($urandom_range(0, 9) < 7);
      cycle(v, ra, rb, rm, il, ordy);
      n_checks++;
      if ({obs_ov8, obs_ready8} !== {obs_ov, obs_ready})
        $display("FAIL rnd_lockstep: got valid8=%b ready8=%b expected valid=%b ready=%b",
                 obs_ov8, obs_ready8, obs_ov, obs_ready);
      else n_pass++;
      if (hold) begin
        n_checks++;
        if ({obs_ov, obs_out, obs_cnt} !== {1'b1, held_out, held_cnt})
          $display("FAIL rnd_hold: got valid=%b out=%0d cnt=%0d expected valid=1 out=%0d cnt=%0d",
                   obs_ov, obs_out, obs_cnt, held_out, held_cnt);
        else n_pass++;
      end
      hold     = obs_ov && !ordy;
      held_out = obs_out;
      held_cnt = obs_cnt;
      if (obs_ov && ordy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_result: unexpected output out=%0d", $signed(obs_out));
        end else begin
          e = exp_q.pop_front();
          if ({obs_out, obs_sat, obs_cnt, obs_out8, obs_sat8, obs_cnt8} !==
              {e.out0, e.sat0, e.cnt, e.out8, e.sat8, e.cnt})
            $display("FAIL rnd_result: got out=%0d sat=%b cnt=%0d out8=%0d sat8=%b expected out=%0d sat=%b cnt=%0d out8=%0d sat8=%b",
                     $signed(obs_out), obs_sat, obs_cnt, $signed(obs_out8), obs_sat8,
                     $signed(e.out0), e.sat0, e.cnt, $signed(e.out8), e.sat8);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d results still pending expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    mode      = 2'b00;
    reset     = 1'b1;
    model_clear();
    test_reset();
    test_mac();
    test_add_stream();
    test_saturation();
    test_backpressure();
    test_rounding();
    test_reset_mid();
    test_count_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_seq_mac.md
PARAM_SEQ_MAC -- requirements
Module: param_seq_mac

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, operand and result width (signed two's complement).
REQ-002 SHALL have parameter ACC_WIDTH, default 40, accumulator width; ACC_WIDTH >= 2*DWIDTH.
REQ-003 SHALL have parameter FRAC_BITS, default 8, right-shift applied before the output downcast.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of the element counter.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  an operand pair is presented.
REQ-008 SHALL have port in_ready  output  1  block accepts the operand pair this cycle.
REQ-009 SHALL have port a  input  DWIDTH  signed operand A.
REQ-010 SHALL have port b  input  DWIDTH  signed operand B.
REQ-011 SHALL have port mode  input  2  00 MAC, 01 element-wise add, 10 element-wise multiply, 11 treated as 00.
REQ-012 SHALL have port in_last  input  1  final element of the current MAC sequence; ignored in modes 01/10.
REQ-013 SHALL have port out_valid  output  1  out holds a result.
REQ-014 SHALL have port out_ready  input  1  consumer takes the result.
REQ-015 SHALL have port out  output  DWIDTH  saturated result.
REQ-016 SHALL have port out_sat  output  1  result was clamped.
REQ-017 SHALL have port out_count  output  CNT_WIDTH  number of elements folded into the result.

Function
REQ-018 SHALL accept an element when in_valid && in_ready; in_ready = !(out_valid && !out_ready); every pipeline register advances only when that enable is 1.
REQ-019 SHALL be a 3-stage pipeline: S1 registers a, b, mode, last; S2 computes a*b (mode 00/10) or sign-extended a+b (mode 01) at 2*DWIDTH; S3 accumulates/downcasts into the output register.
REQ-020 SHALL present the result of an element accepted at cycle N on out_valid at N+3 with no stall; stalls add cycles 1:1.
REQ-021 SHALL implement FSM IDLE/ACCUM: IDLE + accepted MAC element not last -> ACCUM; ACCUM + accepted element with in_last -> IDLE; element-wise elements never leave IDLE.
REQ-022 SHALL latch mode on the first element of a MAC sequence; mode on later elements of the sequence SHALL be ignored until in_last.
REQ-023 SHALL in MAC mode form acc = sum of sign-extended products, wrapping modulo 2^ACC_WIDTH, and emit one result only on the in_last element; a single element with in_last in IDLE yields that product.
REQ-024 SHALL in modes 01/10 emit one result per accepted element, not touching the accumulator.
REQ-025 SHALL downcast: arithmetic shift right by FRAC_BITS, then clamp to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]; out_sat = 1 iff clamped.
REQ-026 SHALL set out_count to elements in the sequence (1 for element-wise), saturating at 2^CNT_WIDTH-1.
REQ-027 SHALL hold out, out_sat, out_count, out_valid stable while out_valid && !out_ready.
REQ-028 SHALL allow a new sequence's first element to be accepted the cycle after the previous in_last, with no bubble.

Reset
REQ-029 SHALL on reset clear out=0, out_sat=0, out_count=0, out_valid=0, accumulator, counter, all pipeline valids, FSM=IDLE.
REQ-030 SHALL discard any in-flight element or partial sum when reset asserts mid-sequence; in_ready = 1 during and after reset.

Configuration
REQ-031 SHALL, with SEQ_MAC_ROUND_EN defined, add 2^(FRAC_BITS-1) (round-half-up) before the shift in REQ-025 when FRAC_BITS > 0; without it, truncate.

Verification
REQ-032 SHALL test MAC: (2,3),(4,5),(-1,6) last, FRAC_BITS=0 -> out=20, out_count=3, out_sat=0, out_valid 3 cycles after last.
REQ-033 SHALL test saturation: mode 10, a=b=0x7FFF, FRAC_BITS=0 -> out=0x7FFF, out_sat=1; a=0x8000,b=0x7FFF -> out=0x8000, out_sat=1.
REQ-034 SHALL test backpressure: out_ready=0 for 5 cycles with a result pending -> in_ready=0, out stable, no element lost after release.
REQ-035 SHALL test reset mid-sequence: 2 MAC elements, reset, then (7,1) last -> out=7, out_count=1.
REQ-036 SHALL test mode 01 streaming: (100,-30) then (5,5) back-to-back -> out 70 then 10 on consecutive cycles.
REQ-037 SHALL test rounding: FRAC_BITS=8, MAC single product 384 -> out=2 with SEQ_MAC_ROUND_EN, out=1 without.
